// File: rtl/rom_rd_arbiter.sv
// Round-robin arbiter and burst sequencer sharing one asynchronous 64x4 ROM
// between NREQ requesters. A winner gets a one-cycle grant, then 1..4
// consecutive ROM words come back as registered rdata with a one-hot
// rvalid strobe on the owner. One IDLE cycle always separates two bursts.
//
// Handshake: req is a level. It is sampled only in IDLE. addr_in and len_in
// are captured at the grant edge. gnt is a one-cycle pulse. rvalid[i] marks
// a beat for requester i in the cycle it is high. There is no back-pressure.
module rom_rd_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 6,
  parameter int DW   = 4,
  parameter int LW   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   addr_in,
  input  logic [NREQ*LW-1:0]   len_in,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rvalid,
  output logic [DW-1:0]        rdata,
  output logic                 busy,
  output logic                 rom_en,
  output logic [AW-1:0]        rom_addr,
  input  logic [DW-1:0]        rom_dout
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t          state, state_next;
  logic [PW-1:0]   ptr, ptr_next;
  logic [PW-1:0]   owner, owner_next;
  logic [LW-1:0]   cnt, cnt_next;
  logic [NREQ-1:0] gnt_next, rvalid_next;
  logic [DW-1:0]   rdata_next;
  logic            busy_next, rom_en_next;
  logic [AW-1:0]   rom_addr_next;

  logic [PW-1:0]   win;
  logic            found;
  int              idx;

  // Rotating priority search: first set req bit starting at ptr+1, wrapping.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    idx   = 0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: a burst starts on any request and ends after its last beat.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = BURST;
      BURST:   if (cnt == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output/datapath next values; every output is registered below.
  always_comb begin
    ptr_next      = ptr;
    owner_next    = owner;
    cnt_next      = cnt;
    gnt_next      = '0;
    rvalid_next   = '0;
    rdata_next    = rdata;
    busy_next     = busy;
    rom_en_next   = rom_en;
    rom_addr_next = rom_addr;
    case (state)
      IDLE: begin
        busy_next   = 1'b0;
        rom_en_next = 1'b0;
        if (found) begin
          gnt_next[win] = 1'b1;
          rom_addr_next = addr_in[int'(win)*AW +: AW];
          cnt_next      = len_in[int'(win)*LW +: LW];
          rom_en_next   = 1'b1;
          busy_next     = 1'b1;
          owner_next    = win;
          ptr_next      = win;
        end
      end
      BURST: begin
        rdata_next         = rom_dout;
        rvalid_next[owner] = 1'b1;
        if (cnt != '0) begin
          rom_addr_next = rom_addr + AW'(1);
          cnt_next      = cnt - LW'(1);
        end else begin
          rom_en_next = 1'b0;
          busy_next   = 1'b0;
        end
      end
      default: begin
        busy_next   = 1'b0;
        rom_en_next = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; reset drops any burst in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= PW'(NREQ - 1);
      owner    <= '0;
      cnt      <= '0;
      gnt      <= '0;
      rvalid   <= '0;
      rdata    <= '0;
      busy     <= 1'b0;
      rom_en   <= 1'b0;
      rom_addr <= '0;
    end else begin
      ptr      <= ptr_next;
      owner    <= owner_next;
      cnt      <= cnt_next;
      gnt      <= gnt_next;
      rvalid   <= rvalid_next;
      rdata    <= rdata_next;
      busy     <= busy_next;
      rom_en   <= rom_en_next;
      rom_addr <= rom_addr_next;
    end
  end

endmodule

// File: tb/tb_rom_rd_arbiter.sv
// Testbench for rom_rd_arbiter: directed scenarios followed by random traffic,
// all checked every cycle against a transaction-level schedule model.
module tb_rom_rd_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 6;
  localparam int DW   = 4;
  localparam int LW   = 2;
  localparam int EW   = 2*NREQ + DW + 2 + AW;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*AW-1:0] addr_in = '0;
  logic [NREQ*LW-1:0] len_in = '0;
  logic [NREQ-1:0]    gnt, rvalid;
  logic [DW-1:0]      rdata, rom_dout;
  logic               busy, rom_en;
  logic [AW-1:0]      rom_addr;

  logic [DW-1:0]      rom_mem [2**AW];
  logic [EW-1:0]      obs;

  // Reference model state
  logic [EW-1:0]      exp_q[$];
  logic [EW-1:0]      cur_exp;
  int                 m_ptr;
  logic [DW-1:0]      m_rdata;
  logic [AW-1:0]      m_addr;

  // Directed-scenario logs
  logic [DW-1:0]      got_q[$];
  int                 gnt_log[$];

  int total = 0;
  int bad = 0;

  rom_rd_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .addr_in(addr_in), .len_in(len_in),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_dout(rom_dout)
  );

  // Clock and ROM model
  always #5 clk = ~clk;

  initial begin
    for (int a = 0; a < 2**AW; a++) rom_mem[a] = DW'(a);
  end

  assign rom_dout = rom_mem[rom_addr];
  assign obs = {gnt, rvalid, rdata, busy, rom_en, rom_addr};

  function automatic logic [NREQ-1:0] onehot(input int w);
    logic [NREQ-1:0] v;
    v = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  function automatic logic [EW-1:0] pack(input logic [NREQ-1:0] g, input logic [NREQ-1:0] r,
                                         input logic [DW-1:0] d, input logic b, input logic en,
                                         input logic [AW-1:0] ad);
    return {g, r, d, b, en, ad};
  endfunction

  task automatic check(input string tag, input logic [EW-1:0] o, input logic [EW-1:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed={gnt,rvalid,rdata,busy,en,addr}=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check_int(input string tag, input int o, input int e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ptr   = NREQ - 1;
    m_rdata = '0;
    m_addr  = '0;
  endtask

  // Called at each rising edge: if no burst is scheduled, arbitrate on the
  // sampled req and schedule the whole burst (grant cycle + L beat cycles).
  task automatic model_edge();
    int w, len, i;
    logic [AW-1:0] a, ba, shown;
    if (exp_q.size() == 0) begin
      if (req != '0) begin
        w = -1;
        for (int k = 1; k <= NREQ; k++) begin
          i = (m_ptr + k) % NREQ;
          if (w < 0 && req[i]) w = i;
        end
        a     = addr_in[w*AW +: AW];
        len   = int'(len_in[w*LW +: LW]) + 1;
        m_ptr = w;
        exp_q.push_back(pack(onehot(w), '0, m_rdata, 1'b1, 1'b1, a));
        for (int k = 1; k <= len; k++) begin
          ba    = a + AW'(k - 1);
          shown = (k < len) ? a + AW'(k) : ba;
          exp_q.push_back(pack('0, onehot(w), rom_mem[ba], k < len, k < len, shown));
        end
      end else begin
        exp_q.push_back(pack('0, '0, m_rdata, 1'b0, 1'b0, m_addr));
      end
    end
    cur_exp = exp_q.pop_front();
    m_addr  = cur_exp[AW-1:0];
    m_rdata = cur_exp[AW+2 +: DW];
  endtask

  // One clock cycle: model at the edge, compare 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check(tag, obs, cur_exp);
    if (rvalid != '0) got_q.push_back(rdata);
    if (gnt != '0) gnt_log.push_back($clog2(gnt));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    #1;
    check("reset_clear", obs, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_req_cfg(input int r, input int a, input int l);
    addr_in[r*AW +: AW] = AW'(a);
    len_in[r*LW +: LW]  = LW'(l);
  endtask

  initial begin
    logic [DW-1:0] want[$];
    int            want_g[$];

    #3;
    do_reset();

    // Single burst: requester 0, address 10, four beats
    set_req_cfg(0, 10, 3);
    req = 4'b0001;
    got_q.delete();
    step("t1_grant");
    req = '0;
    repeat (6) step("t1_burst");
    want = '{4'hA, 4'hB, 4'hC, 4'hD};
    check_int("t1_beats", got_q.size(), 4);
    for (int k = 0; k < 4 && k < got_q.size(); k++) check_int("t1_rdata", int'(got_q[k]), int'(want[k]));

    // Address wrap 62,63,0,1
    set_req_cfg(1, 62, 3);
    req = 4'b0010;
    got_q.delete();
    step("wrap_grant");
    req = '0;
    repeat (6) step("wrap_burst");
    want = '{4'hE, 4'hF, 4'h0, 4'h1};
    check_int("wrap_beats", got_q.size(), 4);
    for (int k = 0; k < 4 && k < got_q.size(); k++) check_int("wrap_rdata", int'(got_q[k]), int'(want[k]));

    // Contention: all four requesting single beats
    do_reset();
    for (int r = 0; r < NREQ; r++) set_req_cfg(r, r*16 + r, 0);
    req = 4'b1111;
    got_q.delete();
    gnt_log.delete();
    repeat (10) step("cont");
    req = '0;
    repeat (2) step("cont_drain");
    want_g = '{0, 1, 2, 3, 0};
    want   = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h0};
    check_int("cont_grants", gnt_log.size(), 5);
    check_int("cont_beats", got_q.size(), 5);
    for (int k = 0; k < 5 && k < gnt_log.size(); k++) check_int("cont_order", gnt_log[k], want_g[k]);
    for (int k = 0; k < 5 && k < got_q.size(); k++) check_int("cont_rdata", int'(got_q[k]), int'(want[k]));

    // Fairness after a middle grant: ptr=1, then req 0 and 1 together
    do_reset();
    for (int r = 0; r < NREQ; r++) set_req_cfg(r, r, 0);
    gnt_log.delete();
    req = 4'b0010;
    step("fair_g1");
    req = 4'b0011;
    repeat (5) step("fair");
    req = '0;
    repeat (2) step("fair_drain");
    want_g = '{1, 0, 1};
    check_int("fair_grants", gnt_log.size(), 3);
    for (int k = 0; k < 3 && k < gnt_log.size(); k++) check_int("fair_order", gnt_log[k], want_g[k]);

    // Reset during beat 2 of a four-beat burst
    set_req_cfg(0, 20, 3);
    req = 4'b0001;
    step("mrst_grant");
    req = '0;
    step("mrst_beat1");
    step("mrst_beat2");
    rst_n = 1'b0;
    #1;
    check("mrst_clear", obs, '0);
    model_reset();
    #2 rst_n = 1'b1;
    got_q.delete();
    repeat (8) step("mrst_after");
    check_int("mrst_no_beats", got_q.size(), 0);

    // Idle stretch: establish a non-zero rom_addr first, then 20 quiet cycles
    set_req_cfg(2, 45, 1);
    req = 4'b0100;
    step("idle_setup");
    req = '0;
    repeat (3) step("idle_setup_burst");
    repeat (20) step("idle");

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      req = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom_range(0, 2**NREQ - 1));
      for (int r = 0; r < NREQ; r++) set_req_cfg(r, $urandom_range(0, 2**AW - 1), $urandom_range(0, 2**LW - 1));
      step("rand");
    end
    req = '0;
    repeat (6) step("rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
